// File: rtl/multicycle_core.sv
// -----------------------------------------------------------------------------
// multicycle_core
//
// Multi-cycle PC/IR/regfile/ALU core. Each instruction passes through four
// states: FETCH -> DECODE -> EXECUTE -> WRITEBACK. Instructions come in over a
// req/ack instruction-memory port. The core stops for good on a HALT opcode,
// and only a reset restarts it.
//
// Instruction word:
//   [30] NEG  [29] IMM  [28] BZ  [27] JMP  [26:24] ALUOP
//   [23:16] dst  [15:8] src1  [7:0] src2/imm
//   A = IMM ? zext(imm) : R[src1]
//   B = NEG ? -R[src2]  : R[src2]
//   ALUOP: 000 A, 001 A+B, 010 A&B, 011 A|B, 100 A^B, 101 A>>1, 110 0, 111 HALT
//
// Optional feature macro: CORE_BRANCH_EN
//   When defined, BZ/JMP redirect the PC in WRITEBACK. These instructions
//   write no register and leave zero_flag unchanged. When undefined, bits
//   [28:27] are ignored and every instruction runs as an ALU op.
//
// Parameters:
//   DATA_W  register/ALU width (>= 8)
//   REG_AW  register address width, 2**REG_AW registers (<= 8)
//   PC_W    PC / fetch address width, word addressed (<= 8)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   imem_req   fetch request, held until the ack cycle
//   imem_addr  fetch address (the PC)
//   imem_ack   instruction valid this cycle
//   imem_data  instruction word
//   wb_en      one-cycle register write strobe
//   wb_addr    register written (holds when wb_en=0)
//   wb_data    value written (holds when wb_en=0)
//   zero_flag  last written ALU result was zero
//   halted     core stopped on HALT
// -----------------------------------------------------------------------------
module multicycle_core #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3,
  parameter int PC_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_data,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              zero_flag,
  output logic              halted
);

  localparam int NREGS = 2 ** REG_AW;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_HALT      = 3'd4
  } state_t;

  state_t              state_reg, state_next;
  logic                req_reg, req_next;
  logic [PC_W-1:0]     pc_reg, pc_next;
  logic [31:0]         ir_reg;
  logic [DATA_W-1:0]   a_reg, b_reg, result_reg;
  logic [DATA_W-1:0]   regs_reg [NREGS];
  logic                wb_en_reg, zero_reg, halted_reg;
  logic [REG_AW-1:0]   wb_addr_reg;
  logic [DATA_W-1:0]   wb_data_reg;

  // Strobes from the sequencer to the datapath
  logic latch_ir, latch_ops, latch_result, commit_write, set_halt;

  // Instruction fields
  logic              ir_neg, ir_imm;
  logic [2:0]        ir_op;
  logic [REG_AW-1:0] ir_dst, ir_src1, ir_src2;
  logic [7:0]        ir_imm8;
  logic              is_halt;
  logic              ir_unused;

  assign ir_neg  = ir_reg[30];
  assign ir_imm  = ir_reg[29];
  assign ir_op   = ir_reg[26:24];
  assign ir_dst  = ir_reg[16 +: REG_AW];
  assign ir_src1 = ir_reg[8 +: REG_AW];
  assign ir_src2 = ir_reg[0 +: REG_AW];
  assign ir_imm8 = ir_reg[7:0];
  assign is_halt = (ir_op == OP_HALT);
  // Bits [31] and the upper bits of the register fields carry no meaning.
  assign ir_unused = ^ir_reg;

`ifdef CORE_BRANCH_EN
  logic ir_bz, ir_jmp;
  assign ir_bz  = ir_reg[28];
  assign ir_jmp = ir_reg[27];
`endif

  // Operand selection (sampled into a_reg/b_reg in DECODE)
  logic [DATA_W-1:0] rs1_val, rs2_val, operand_a, operand_b;
  assign rs1_val   = regs_reg[ir_src1];
  assign rs2_val   = regs_reg[ir_src2];
  assign operand_a = ir_imm ? DATA_W'(ir_imm8) : rs1_val;
  assign operand_b = ir_neg ? -rs2_val : rs2_val;

  // ALU; the carry out of A+B is dropped
  logic [DATA_W-1:0] alu_result;
  always_comb begin
    alu_result = '0;
    case (ir_op)
      OP_PASS: alu_result = a_reg;
      OP_ADD:  alu_result = a_reg + b_reg;
      OP_AND:  alu_result = a_reg & b_reg;
      OP_OR:   alu_result = a_reg | b_reg;
      OP_XOR:  alu_result = a_reg ^ b_reg;
      OP_SHR:  alu_result = a_reg >> 1;
      default: alu_result = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequencer: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= ST_FETCH;
      req_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      req_reg   <= req_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer: next state and datapath strobes
  // imem_req is registered. After reset the first FETCH cycle therefore only
  // raises the request, and an ack seen while the request is low is ignored.
  // WRITEBACK raises the request for the next fetch ahead of time, so a
  // zero-wait fetch takes a single cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    req_next     = 1'b0;
    pc_next      = pc_reg;
    latch_ir     = 1'b0;
    latch_ops    = 1'b0;
    latch_result = 1'b0;
    commit_write = 1'b0;
    set_halt     = 1'b0;
    case (state_reg)
      ST_FETCH: begin
        if (req_reg && imem_ack) begin
          latch_ir   = 1'b1;
          state_next = ST_DECODE;
        end else begin
          req_next = 1'b1;
        end
      end
      ST_DECODE: begin
        latch_ops  = 1'b1;
        state_next = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        latch_result = 1'b1;
        state_next   = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        // HALT is decoded before the control-flow bits.
        if (is_halt) begin
          set_halt   = 1'b1;
          state_next = ST_HALT;
        end else begin
          state_next = ST_FETCH;
          req_next   = 1'b1;
          pc_next    = pc_reg + PC_W'(1);
`ifdef CORE_BRANCH_EN
          if (ir_jmp) begin
            pc_next = ir_reg[PC_W-1:0];
          end else if (ir_bz) begin
            if (zero_reg) begin
              pc_next = ir_reg[PC_W-1:0];
            end
          end else begin
            commit_write = 1'b1;
          end
`else
          commit_write = 1'b1;
`endif
        end
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_FETCH;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_reg      <= '0;
      ir_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      result_reg  <= '0;
      wb_en_reg   <= 1'b0;
      wb_addr_reg <= '0;
      wb_data_reg <= '0;
      zero_reg    <= 1'b0;
      halted_reg  <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      wb_en_reg <= commit_write;
      if (latch_ir) begin
        ir_reg <= imem_data;
      end
      if (latch_ops) begin
        a_reg <= operand_a;
        b_reg <= operand_b;
      end
      if (latch_result) begin
        result_reg <= alu_result;
      end
      if (commit_write) begin
        wb_addr_reg <= ir_dst;
        wb_data_reg <= result_reg;
        zero_reg    <= (result_reg == '0);
      end
      if (set_halt) begin
        halted_reg <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register file: one write port committed in WRITEBACK. Reads happen in
  // DECODE, after the previous instruction has committed, so there are no
  // hazards.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_regfile
      always_ff @(posedge clk) begin
        if (!reset) begin
          regs_reg[gi] <= '0;
        end else if (commit_write && (ir_dst == REG_AW'(gi))) begin
          regs_reg[gi] <= result_reg;
        end
      end
    end
  endgenerate

  assign imem_req  = req_reg;
  assign imem_addr = pc_reg;
  assign wb_en     = wb_en_reg;
  assign wb_addr   = wb_addr_reg;
  assign wb_data   = wb_data_reg;
  assign zero_flag = zero_reg;
  assign halted    = halted_reg;

endmodule

// File: tb/tb_multicycle_core.sv
// -----------------------------------------------------------------------------
// tb_multicycle_core
//
// Directed testbench for multicycle_core with default parameters
// (DATA_W=8, REG_AW=3, PC_W=8).
//
// An instruction-memory model answers fetches from a program table. Each
// address has its own number of ack wait states. Every test task loads its
// program, resets the core and compares the observed behaviour against
// hand-computed values. DUT outputs are sampled 1 ns after the rising edge.
// The memory model drives its inputs on the falling edge.
// -----------------------------------------------------------------------------
module tb_multicycle_core;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [7:0]  wb_data;
  logic        zero_flag;
  logic        halted;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [256];
  int          dly [256];
  int          wait_cnt = 0;
  bit          ack_force = 1'b0;

  multicycle_core #(.DATA_W(8), .REG_AW(3), .PC_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .zero_flag (zero_flag),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: acks after dly[addr] wait cycles of an active request.
  always @(negedge clk) begin
    if (ack_force) begin
      imem_ack  = 1'b1;
      imem_data = 32'hFFFF_FFFF;
    end else if (imem_req && (wait_cnt >= dly[imem_addr])) begin
      imem_ack  = 1'b1;
      imem_data = mem[imem_addr];
      wait_cnt  = 0;
    end else begin
      imem_ack = 1'b0;
      if (imem_req) wait_cnt++;
    end
  end

  function automatic logic [31:0] enc(input logic neg, input logic imm,
                                      input logic bz, input logic jmp,
                                      input logic [2:0] op, input logic [7:0] dst,
                                      input logic [7:0] s1, input logic [7:0] s2);
    return {1'b0, neg, imm, bz, jmp, op, dst, s1, s2};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'h0;
      dly[i] = 0;
    end
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    wait_cnt = 0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Waits (bounded) for the next wb_en pulse; n = cycles waited.
  task automatic wait_wb(output bit got, output int n);
    got = 1'b0;
    n   = 0;
    while (!got && n < 40) begin
      tick();
      n++;
      if (wb_en === 1'b1) got = 1'b1;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    bit got;
    int n;
    clear_mem();
    ack_force = 1'b1;
    reset     = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({imem_req, wb_en, zero_flag, halted} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_ctrl: req/wb_en/zero/halted = %b, required 0000",
               {imem_req, wb_en, zero_flag, halted});
    end
    n_checks++;
    if ({imem_addr, wb_addr, wb_data} !== 19'h0) begin
      n_errors++;
      $display("FAIL reset_data: addr=%h wb_addr=%h wb_data=%h, required all 0",
               imem_addr, wb_addr, wb_data);
    end
    // Release reset. The forced ack stays up over the first edge; the core
    // must ignore it because its request is still low.
    reset = 1'b1;
    tick();
    ack_force = 1'b0;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_first_fetch: req=%b addr=%h, required req=1 addr=00",
               imem_req, imem_addr);
    end
    wait_wb(got, n);
    n_checks++;
    if (!got || wb_addr !== 3'd0 || wb_data !== 8'h00 || zero_flag !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_first_instr: got=%b addr=%h data=%h zero=%b, required 1 0 00 1",
               got, wb_addr, wb_data, zero_flag);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_load_add();
    logic [2:0] ea [3];
    logic [7:0] ed [3];
    bit got;
    int n;
    ea = '{3'd1, 3'd2, 3'd3};
    ed = '{8'h05, 8'h03, 8'h08};
    clear_mem();
    mem[0] = enc(0, 1, 0, 0, 3'b000, 8'd1, 8'd0, 8'h05);
    mem[1] = enc(0, 1, 0, 0, 3'b000, 8'd2, 8'd0, 8'h03);
    mem[2] = enc(0, 0, 0, 0, 3'b001, 8'd3, 8'd1, 8'd2);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wait_wb(got, n);
      n_checks++;
      if (!got) begin
        n_errors++;
        $display("FAIL load_add[%0d] timeout: no wb_en after %0d cycles", i, n);
      end else begin
        n_checks++;
        if (wb_addr !== ea[i] || wb_data !== ed[i]) begin
          n_errors++;
          $display("FAIL load_add[%0d]: wb R%0d=%h, required R%0d=%h",
                   i, wb_addr, wb_data, ea[i], ed[i]);
        end
        if (i > 0) begin
          n_checks++;
          if (n !== 4) begin
            n_errors++;
            $display("FAIL load_add_period[%0d]: %0d cycles, required 4", i, n);
          end
        end
      end
    end
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'd3) begin
      n_errors++;
      $display("FAIL load_add_pc: req=%b addr=%h, required req=1 addr=03", imem_req, imem_addr);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_subtract();
    logic [2:0] ea [5];
    logic [7:0] ed [5];
    logic       ez [5];
    bit got;
    int n;
    ea = '{3'd1, 3'd2, 3'd4, 3'd1, 3'd5};
    ed = '{8'h05, 8'h05, 8'h00, 8'h03, 8'hFE};
    ez = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    clear_mem();
    mem[0] = enc(0, 1, 0, 0, 3'b000, 8'd1, 8'd0, 8'h05);
    mem[1] = enc(0, 1, 0, 0, 3'b000, 8'd2, 8'd0, 8'h05);
    mem[2] = enc(1, 0, 0, 0, 3'b001, 8'd4, 8'd1, 8'd2);
    mem[3] = enc(0, 1, 0, 0, 3'b000, 8'd1, 8'd0, 8'h03);
    mem[4] = enc(1, 0, 0, 0, 3'b001, 8'd5, 8'd1, 8'd2);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wait_wb(got, n);
      n_checks++;
      if (!got || wb_addr !== ea[i] || wb_data !== ed[i] || zero_flag !== ez[i]) begin
        n_errors++;
        $display("FAIL subtract[%0d]: got=%b R%0d=%h zero=%b, required R%0d=%h zero=%b",
                 i, got, wb_addr, wb_data, zero_flag, ea[i], ed[i], ez[i]);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_alu_ops();
    logic [2:0] ea [11];
    logic [7:0] ed [11];
    logic       ez [11];
    bit got;
    int n;
    ea = '{3'd1, 3'd2, 3'd6, 3'd3, 3'd3, 3'd3, 3'd7, 3'd1, 3'd2, 3'd3, 3'd4};
    ed = '{8'h03, 8'h05, 8'h21, 8'h01, 8'h07, 8'h06, 8'h10, 8'h00, 8'h87, 8'h0E, 8'h43};
    ez = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    clear_mem();
    mem[0]  = enc(0, 1, 0, 0, 3'b000, 8'd1, 8'd0, 8'h03);
    mem[1]  = enc(0, 1, 0, 0, 3'b000, 8'd2, 8'd0, 8'h05);
    mem[2]  = enc(0, 1, 0, 0, 3'b000, 8'd6, 8'd0, 8'h21);
    mem[3]  = enc(0, 0, 0, 0, 3'b010, 8'd3, 8'd1, 8'd2);   // 3 & 5
    mem[4]  = enc(0, 0, 0, 0, 3'b011, 8'd3, 8'd1, 8'd2);   // 3 | 5
    mem[5]  = enc(0, 0, 0, 0, 3'b100, 8'd3, 8'd1, 8'd2);   // 3 ^ 5
    mem[6]  = enc(0, 0, 0, 0, 3'b101, 8'd7, 8'd6, 8'd0);   // 0x21 >> 1
    mem[7]  = enc(0, 0, 0, 0, 3'b110, 8'd1, 8'd1, 8'd2);   // constant 0
    mem[8]  = enc(0, 1, 0, 0, 3'b001, 8'd2, 8'd0, 8'h82);  // 0x82 + R2(5)
    mem[9]  = enc(0, 0, 0, 0, 3'b001, 8'd3, 8'd2, 8'd2);   // R2 + R2, just written
    mem[10] = enc(0, 0, 0, 0, 3'b101, 8'd4, 8'd2, 8'd0);   // 0x87 >> 1 logical
    do_reset();
    for (int i = 0; i < 11; i++) begin
      wait_wb(got, n);
      n_checks++;
      if (!got || wb_addr !== ea[i] || wb_data !== ed[i] || zero_flag !== ez[i]) begin
        n_errors++;
        $display("FAIL alu_ops[%0d]: got=%b R%0d=%h zero=%b, required R%0d=%h zero=%b",
                 i, got, wb_addr, wb_data, zero_flag, ea[i], ed[i], ez[i]);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_wait_states();
    bit got;
    int n;
    clear_mem();
    mem[0] = enc(0, 1, 0, 0, 3'b000, 8'd6, 8'd0, 8'h21);
    mem[1] = enc(0, 0, 0, 0, 3'b000, 8'd7, 8'd6, 8'd0);
    dly[1] = 3;
    do_reset();
    wait_wb(got, n);
    n_checks++;
    if (!got || wb_data !== 8'h21) begin
      n_errors++;
      $display("FAIL wait_first: got=%b data=%h, required 1 21", got, wb_data);
    end
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'd1) begin
      n_errors++;
      $display("FAIL wait_req_start: req=%b addr=%h, required 1 01", imem_req, imem_addr);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 8'd1) begin
        n_errors++;
        $display("FAIL wait_hold[%0d]: req=%b addr=%h, required 1 01", i, imem_req, imem_addr);
      end
    end
    wait_wb(got, n);
    n_checks++;
    if (!got || (n + 3) !== 7) begin
      n_errors++;
      $display("FAIL wait_period: got=%b period=%0d cycles, required 7", got, n + 3);
    end
    n_checks++;
    if (wb_addr !== 3'd7 || wb_data !== 8'h21) begin
      n_errors++;
      $display("FAIL wait_data: R%0d=%h, required R7=21", wb_addr, wb_data);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_halt();
    bit got;
    int n;
    int pulses;
    clear_mem();
    for (int i = 0; i < 4; i++) begin
      mem[i] = enc(0, 1, 0, 0, 3'b000, 8'(i + 1), 8'd0, 8'(i + 10));
    end
    mem[4] = enc(0, 0, 0, 0, 3'b111, 8'd5, 8'd1, 8'd2);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wait_wb(got, n);
      n_checks++;
      if (!got || wb_data !== 8'(i + 10)) begin
        n_errors++;
        $display("FAIL halt_prelude[%0d]: got=%b data=%h, required %h", i, got, wb_data, 8'(i + 10));
      end
    end
    n_checks++;
    if (halted !== 1'b0) begin
      n_errors++;
      $display("FAIL halt_early: halted=%b before HALT executed, required 0", halted);
    end
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (wb_en === 1'b1) pulses++;
    end
    n_checks++;
    if (halted !== 1'b1 || imem_req !== 1'b0) begin
      n_errors++;
      $display("FAIL halt_state: halted=%b req=%b, required halted=1 req=0", halted, imem_req);
    end
    n_checks++;
    if (pulses !== 0) begin
      n_errors++;
      $display("FAIL halt_no_write: %0d wb_en pulses after HALT, required 0", pulses);
    end
    do_reset();
    n_checks++;
    if (halted !== 1'b0) begin
      n_errors++;
      $display("FAIL halt_cleared: halted=%b after reset, required 0", halted);
    end
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'd0) begin
      n_errors++;
      $display("FAIL halt_restart: req=%b addr=%h, required 1 00", imem_req, imem_addr);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_branch();
    bit got;
    int n;
    int pulses;
    clear_mem();
    mem[0]     = enc(0, 0, 0, 0, 3'b110, 8'd1, 8'd0, 8'd0);   // R1 = 0, zero=1
    mem[1]     = enc(0, 1, 1, 0, 3'b000, 8'd2, 8'd0, 8'h10);  // BZ 0x10
    mem[2]     = enc(0, 1, 0, 1, 3'b000, 8'd3, 8'd0, 8'hFF);  // JMP 0xFF
    mem[8'h10] = enc(0, 1, 0, 1, 3'b000, 8'd3, 8'd0, 8'hFF);  // JMP 0xFF
    mem[8'hFF] = enc(0, 1, 0, 0, 3'b000, 8'd4, 8'd0, 8'h07);  // R4 = 7
    do_reset();
    wait_wb(got, n);
    n_checks++;
    if (!got || wb_addr !== 3'd1 || zero_flag !== 1'b1) begin
      n_errors++;
      $display("FAIL branch_setup: got=%b R%0d zero=%b, required R1 zero=1", got, wb_addr, zero_flag);
    end
`ifdef CORE_BRANCH_EN
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (wb_en === 1'b1) pulses++;
    end
    n_checks++;
    if (imem_addr !== 8'h10 || imem_req !== 1'b1 || pulses !== 0 || zero_flag !== 1'b1) begin
      n_errors++;
      $display("FAIL branch_bz: addr=%h req=%b pulses=%0d zero=%b, required 10 1 0 1",
               imem_addr, imem_req, pulses, zero_flag);
    end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (wb_en === 1'b1) pulses++;
    end
    n_checks++;
    if (imem_addr !== 8'hFF || imem_req !== 1'b1 || pulses !== 0) begin
      n_errors++;
      $display("FAIL branch_jmp: addr=%h req=%b pulses=%0d, required FF 1 0",
               imem_addr, imem_req, pulses);
    end
    wait_wb(got, n);
    n_checks++;
    if (!got || wb_addr !== 3'd4 || wb_data !== 8'h07) begin
      n_errors++;
      $display("FAIL branch_target: got=%b R%0d=%h, required R4=07", got, wb_addr, wb_data);
    end
    n_checks++;
    if (imem_addr !== 8'h00) begin
      n_errors++;
      $display("FAIL branch_wrap: addr=%h, required 00", imem_addr);
    end
`else
    pulses = 0;
    wait_wb(got, n);
    n_checks++;
    if (!got || wb_addr !== 3'd2 || wb_data !== 8'h10 || n !== 4) begin
      n_errors++;
      $display("FAIL nobranch_bz: got=%b R%0d=%h cycles=%0d, required R2=10 in 4",
               got, wb_addr, wb_data, n);
    end
    n_checks++;
    if (imem_addr !== 8'd2) begin
      n_errors++;
      $display("FAIL nobranch_bz_pc: addr=%h, required 02", imem_addr);
    end
    wait_wb(got, n);
    n_checks++;
    if (!got || wb_addr !== 3'd3 || wb_data !== 8'hFF) begin
      n_errors++;
      $display("FAIL nobranch_jmp: got=%b R%0d=%h, required R3=FF", got, wb_addr, wb_data);
    end
    n_checks++;
    if (imem_addr !== 8'd3 || pulses !== 0) begin
      n_errors++;
      $display("FAIL nobranch_jmp_pc: addr=%h, required 03", imem_addr);
    end
`endif
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    reset     = 1'b0;
    imem_ack  = 1'b0;
    imem_data = 32'h0;
    test_reset();
    test_load_add();
    test_subtract();
    test_alu_ops();
    test_wait_states();
    test_halt();
    test_branch();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
